// File: rtl/colour_bbox_pkg.sv
// Shared types and constants for the colour bounding-box detector.
package colour_bbox_pkg;

    localparam logic [3:0] PKT_VIDEO = 4'h0;
    localparam int         X_W       = 11;
    localparam int         Y_W       = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [X_W-1:0] left;
        logic [X_W-1:0] right;
        logic [Y_W-1:0] top;
        logic [Y_W-1:0] bottom;
        logic           valid;
    } bbox_t;

endpackage

// File: rtl/colour_bbox_detector_bbox_tracker.sv
// Per-frame min/max accumulation of matching pixel coordinates, with a
// commit register holding the last completed frame's box.
module bbox_tracker
    import colour_bbox_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clear,
    input  logic           hit,
    input  logic           commit,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output bbox_t          box
);

    logic [X_W-1:0] min_x, max_x, min_x_n, max_x_n;
    logic [Y_W-1:0] min_y, max_y, min_y_n, max_y_n;
    logic           any, any_n;

    // Next-state includes the current pixel so the eop pixel lands in the commit.
    always_comb begin
        min_x_n = min_x;
        max_x_n = max_x;
        min_y_n = min_y;
        max_y_n = max_y;
        any_n   = any;
        if (hit) begin
            if (x < min_x) min_x_n = x;
            if (x > max_x) max_x_n = x;
            if (y < min_y) min_y_n = y;
            if (y > max_y) max_y_n = y;
            any_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            min_x <= '1;
            max_x <= '0;
            min_y <= '1;
            max_y <= '0;
            any   <= 1'b0;
            box   <= '0;
        end else begin
            if (commit) begin
                box.left   <= any_n ? min_x_n : '0;
                box.right  <= any_n ? max_x_n : '0;
                box.top    <= any_n ? min_y_n : '0;
                box.bottom <= any_n ? max_y_n : '0;
                box.valid  <= any_n;
            end
            if (commit || clear) begin
                min_x <= '1;
                max_x <= '0;
                min_y <= '1;
                max_y <= '0;
                any   <= 1'b0;
            end else begin
                min_x <= min_x_n;
                max_x <= max_x_n;
                min_y <= min_y_n;
                max_y <= max_y_n;
                any   <= any_n;
            end
        end
    end

endmodule

// File: rtl/colour_bbox_detector.sv
// Avalon-ST RGB pass-through stage that finds the bounding box of in-window
// pixels per frame and optionally draws the previous frame's box.
module colour_bbox_detector
    import colour_bbox_pkg::*;
#(
    parameter int unsigned IMAGE_W    = 640,
    parameter int unsigned IMAGE_H    = 480,
    parameter logic [7:0]  R_MIN      = 8'd160,
    parameter logic [7:0]  G_MAX      = 8'd80,
    parameter logic [7:0]  B_MAX      = 8'd80,
    parameter logic [23:0] BOX_COLOUR = 24'hFF0000
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           mode,
    input  logic [23:0]    sink_data,
    input  logic           sink_valid,
    input  logic           sink_sop,
    input  logic           sink_eop,
    output logic           sink_ready,
    output logic [23:0]    source_data,
    output logic           source_valid,
    output logic           source_sop,
    output logic           source_eop,
    input  logic           source_ready,
    output logic [X_W-1:0] bbox_left,
    output logic [X_W-1:0] bbox_right,
    output logic [Y_W-1:0] bbox_top,
    output logic [Y_W-1:0] bbox_bottom,
    output logic           bbox_valid,
    output logic           frame_done
);

    typedef enum logic [1:0] {WAIT_SOP, VIDEO, OTHER} state_t;

    localparam logic [X_W-1:0] X_LAST = X_W'(IMAGE_W - 1);
    localparam logic [Y_W-1:0] Y_END  = Y_W'(IMAGE_H);

    state_t         state;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    rgb_t           pix;
    bbox_t          box;
    logic           accept, pixel, hit, commit, clear, on_border, overlay;

    assign sink_ready = !source_valid || source_ready;
    assign accept     = sink_valid && sink_ready;
    assign pix        = sink_data;

    // Pixels past the last active line still flow but are ignored.
    assign pixel  = accept && !sink_sop && (state == VIDEO) && (y < Y_END);
    assign hit    = pixel && (pix.r >= R_MIN) && (pix.g <= G_MAX) && (pix.b <= B_MAX);
    assign commit = accept && !sink_sop && sink_eop && (state == VIDEO);
    assign clear  = accept && sink_sop;

    assign on_border = (((x == box.left) || (x == box.right)) && (y >= box.top) && (y <= box.bottom)) ||
                       (((y == box.top) || (y == box.bottom)) && (x >= box.left) && (x <= box.right));
    assign overlay   = pixel && mode && box.valid && on_border;

    bbox_tracker u_tracker (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .hit     (hit),
        .commit  (commit),
        .x       (x),
        .y       (y),
        .box     (box)
    );

    assign bbox_left   = box.left;
    assign bbox_right  = box.right;
    assign bbox_top    = box.top;
    assign bbox_bottom = box.bottom;
    assign bbox_valid  = box.valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= WAIT_SOP;
            x            <= '0;
            y            <= '0;
            source_data  <= '0;
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= commit;

            if (accept) begin
                source_data  <= overlay ? BOX_COLOUR : sink_data;
                source_sop   <= sink_sop;
                source_eop   <= sink_eop;
                source_valid <= 1'b1;
            end else if (source_ready) begin
                source_valid <= 1'b0;
            end

            // A header always restarts the packet, even without a preceding eop.
            if (accept) begin
                if (sink_sop) begin
                    x <= '0;
                    y <= '0;
                    if (sink_eop)
                        state <= WAIT_SOP;
                    else
                        state <= (sink_data[3:0] == PKT_VIDEO) ? VIDEO : OTHER;
                end else begin
                    case (state)
                        VIDEO: begin
                            if (y < Y_END) begin
                                if (x == X_LAST) begin
                                    x <= '0;
                                    y <= y + 1'b1;
                                end else begin
                                    x <= x + 1'b1;
                                end
                            end
                            if (sink_eop) begin
                                state <= WAIT_SOP;
                                x     <= '0;
                                y     <= '0;
                            end
                        end
                        OTHER:   if (sink_eop) state <= WAIT_SOP;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_colour_bbox_detector.sv
// Directed + randomized bench for colour_bbox_detector on an 8x4 image.
module tb_colour_bbox_detector;

    localparam int          W     = 8;
    localparam int          H     = 4;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREY  = 24'h404040;
    localparam logic [23:0] BOXC  = 24'hFF0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mode = 1'b0;
    logic [23:0] sink_data = '0;
    logic        sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
    logic        sink_ready;
    logic [23:0] source_data;
    logic        source_valid, source_sop, source_eop;
    logic        source_ready = 1'b1;
    logic [10:0] bbox_left, bbox_right;
    logic [9:0]  bbox_top, bbox_bottom;
    logic        bbox_valid, frame_done;

    always #5 clk = ~clk;

    colour_bbox_detector #(.IMAGE_W(W), .IMAGE_H(H)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_ready(sink_ready),
        .source_data(source_data), .source_valid(source_valid),
        .source_sop(source_sop), .source_eop(source_eop), .source_ready(source_ready),
        .bbox_left(bbox_left), .bbox_right(bbox_right), .bbox_top(bbox_top),
        .bbox_bottom(bbox_bottom), .bbox_valid(bbox_valid), .frame_done(frame_done)
    );

    int          n_chk = 0, n_pass = 0;
    int          done_cnt = 0, exp_done = 0, hs_err = 0, pulse_err = 0;
    bit          bp_en = 0, bp_rand = 0;
    logic        fd_prev = 1'b0;
    logic [25:0] out_q[$], exp_q[$];
    logic [23:0] px_q[$];
    logic        m_valid = 1'b0;
    int          m_l = 0, m_r = 0, m_t = 0, m_b = 0;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (source_valid && source_ready) out_q.push_back({source_sop, source_eop, source_data});
        if (frame_done) done_cnt++;
        if (frame_done && fd_prev) pulse_err++;
        if (sink_ready !== (!source_valid || source_ready)) hs_err++;
        fd_prev = frame_done;
    end

    always @(posedge clk) begin
        #1;
        if (bp_en) source_ready = bp_rand ? 1'($urandom_range(0, 1)) : ~source_ready;
        else       source_ready = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit is_match(input logic [23:0] d);
        return (d[23:16] >= 8'd160) && (d[15:8] <= 8'd80) && (d[7:0] <= 8'd80);
    endfunction

    function automatic logic [23:0] rand_px();
        logic [7:0] c[3];
        for (int k = 0; k < 3; k++) begin
            case ($urandom_range(0, 8))
                0: c[k] = 8'd0;
                1: c[k] = 8'd79;
                2: c[k] = 8'd80;
                3: c[k] = 8'd81;
                4: c[k] = 8'd159;
                5: c[k] = 8'd160;
                6: c[k] = 8'd161;
                7: c[k] = 8'd255;
                default: c[k] = 8'($urandom);
            endcase
        end
        return {c[0], c[1], c[2]};
    endfunction

    task automatic fill(input int n, input logic [23:0] c);
        px_q.delete();
        for (int i = 0; i < n; i++) px_q.push_back(c);
    endtask

    task automatic send_beat(input logic [23:0] d, input logic s, input logic e);
        bit acc;
        acc = 0;
        sink_valid = 1'b1; sink_data = d; sink_sop = s; sink_eop = e;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = sink_ready;
            @(posedge clk); #1;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    endtask

    task automatic send_pkt(input logic [23:0] hdr, input bit has_eop);
        send_beat(hdr, 1'b1, 1'b0);
        for (int i = 0; i < px_q.size(); i++)
            send_beat(px_q[i], 1'b0, has_eop && (i == px_q.size() - 1));
    endtask

    // Reference: pixel i sits at (i%W, i/W); box drawn from the last committed frame.
    task automatic model_pkt(input logic [23:0] hdr, input bit has_eop, input logic mode_v);
        bit video, hit;
        int l, r, t, b, x, y, n;
        logic [23:0] o;
        n = px_q.size();
        video = (hdr[3:0] == 4'h0);
        exp_q.push_back({1'b1, 1'b0, hdr});
        hit = 0; l = 1 << 20; r = -1; t = 1 << 20; b = -1;
        for (int i = 0; i < n; i++) begin
            x = i % W; y = i / W; o = px_q[i];
            if (video && y < H) begin
                if (mode_v && m_valid &&
                    ((((x == m_l) || (x == m_r)) && y >= m_t && y <= m_b) ||
                     (((y == m_t) || (y == m_b)) && x >= m_l && x <= m_r)))
                    o = BOXC;
                if (is_match(px_q[i])) begin
                    hit = 1;
                    if (x < l) l = x;
                    if (x > r) r = x;
                    if (y < t) t = y;
                    if (y > b) b = y;
                end
            end
            exp_q.push_back({1'b0, has_eop && (i == n - 1), o});
        end
        if (video && has_eop) begin
            exp_done++;
            m_valid = hit;
            m_l = hit ? l : 0; m_r = hit ? r : 0;
            m_t = hit ? t : 0; m_b = hit ? b : 0;
        end
    endtask

    task automatic check_pkt(input string tag);
        int n;
        for (int k = 0; k < 300 && out_q.size() < exp_q.size(); k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({tag, " beats"}, 64'(out_q.size()), 64'(exp_q.size()));
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s beat%0d", tag, i), 64'(out_q[i]), 64'(exp_q[i]));
        chk({tag, " frame_done"}, 64'(done_cnt), 64'(exp_done));
        chk({tag, " bbox"}, {21'd0, bbox_left, bbox_right, bbox_top, bbox_bottom, bbox_valid},
            {21'd0, 11'(m_l), 11'(m_r), 10'(m_t), 10'(m_b), m_valid});
        out_q.delete(); exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [23:0] hdr;
        int len;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst source_valid", 64'(source_valid), 64'd0);
        chk("rst sink_ready", 64'(sink_ready), 64'd1);
        chk("rst frame_done", 64'(frame_done), 64'd0);
        chk("rst outputs", {21'd0, bbox_left, bbox_right, bbox_top, bbox_bottom, bbox_valid},
            64'd0);
        chk("rst source_data", 64'({source_sop, source_eop, source_data}), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_q.delete();

        // Grey pass-through, mode 0
        fill(W * H, GREY);
        model_pkt(24'h0, 1, 1'b0);
        send_pkt(24'h0, 1);
        @(negedge clk);
        chk("latency eop beat", 64'({source_valid, source_eop, source_data}), {38'd0, 1'b1, 1'b1, GREY});
        chk("done with eop", 64'(frame_done), 64'd1);
        check_pkt("grey");

        // Single red pixel
        fill(W * H, GREY); px_q[2 * W + 3] = RED;
        model_pkt(24'h0, 1, 1'b0); send_pkt(24'h0, 1); check_pkt("red1");

        // Two reds, then an overlay frame
        fill(W * H, GREY); px_q[1 * W + 1] = RED; px_q[2 * W + 5] = RED;
        model_pkt(24'h0, 1, 1'b0); send_pkt(24'h0, 1); check_pkt("red2");
        mode = 1'b1;
        fill(W * H, GREY); px_q[3 * W + 6] = RED;
        model_pkt(24'h0, 1, 1'b1); send_pkt(24'h0, 1); check_pkt("overlay");

        // Alternating backpressure over a full random frame
        bp_en = 1; bp_rand = 0;
        fill(0, GREY);
        for (int i = 0; i < W * H; i++) px_q.push_back(rand_px());
        px_q[$urandom_range(0, W * H - 1)] = RED;
        model_pkt(24'h0, 1, 1'b1); send_pkt(24'h0, 1); check_pkt("backpressure");
        bp_en = 0;

        // Non-video packet
        fill(4, RED);
        model_pkt(24'h00000F, 1, 1'b1); send_pkt(24'h00000F, 1); check_pkt("nonvideo");

        // Missing eop: partial frame discarded, next header restarts
        fill(5, GREY); px_q[2] = RED;
        model_pkt(24'h0, 0, 1'b1); send_pkt(24'h0, 0); check_pkt("noeop");
        fill(W * H, GREY);
        model_pkt(24'h0, 1, 1'b1); send_pkt(24'h0, 1); check_pkt("after_noeop");

        // Reset after 10 pixels; remainder passes through uncounted
        fill(W * H, GREY); px_q[0] = RED;
        send_beat(24'h0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send_beat(px_q[i], 1'b0, 1'b0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_valid = 1'b0; m_l = 0; m_r = 0; m_t = 0; m_b = 0;
        out_q.delete();
        @(negedge clk);
        chk("midrst bbox cleared", {21'd0, bbox_left, bbox_right, bbox_top, bbox_bottom, bbox_valid},
            64'd0);
        @(posedge clk); #1;
        for (int i = 10; i < W * H; i++) begin
            exp_q.push_back({1'b0, i == W * H - 1, px_q[i]});
            send_beat(px_q[i], 1'b0, i == W * H - 1);
        end
        check_pkt("midrst tail");
        fill(W * H, GREY); px_q[3 * W + 7] = RED;
        model_pkt(24'h0, 1, 1'b1); send_pkt(24'h0, 1); check_pkt("after_rst");

        // Randomized frames: short, exact and over-long, random stalls and mode
        for (int f = 0; f < 8; f++) begin
            case ($urandom_range(0, 3))
                0: len = 12;
                1: len = W * H + 4;
                2: len = 20;
                default: len = W * H;
            endcase
            hdr = {20'($urandom), ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0};
            mode = 1'($urandom_range(0, 1));
            bp_en = 1'($urandom_range(0, 1)); bp_rand = 1;
            px_q.delete();
            for (int i = 0; i < len; i++) px_q.push_back(rand_px());
            model_pkt(hdr, 1, mode); send_pkt(hdr, 1);
            bp_en = 0;
            check_pkt($sformatf("rand%0d", f));
        end

        chk("handshake ready", 64'(hs_err), 64'd0);
        chk("frame_done width", 64'(pulse_err), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/colour_bbox_detector.md
Name: colour_bbox_detector

Overview:
- Avalon-ST video processing stage between the camera/frame-buffer stream and the clocked-video output (ITC).
- Passes 24-bit RGB video through with one register stage of latency.
- Finds the bounding box of pixels inside a programmable colour window for each frame.
- When mode=1, overlays the previous frame's box on the outgoing video. The box is also published for the rover's Nios software.

Parameters:
- IMAGE_W, 640, active pixels per line.
- IMAGE_H, 480, active lines per frame.
- R_MIN, 8'd160, match requires R >= R_MIN.
- G_MAX, 8'd80, match requires G <= G_MAX.
- B_MAX, 8'd80, match requires B <= B_MAX.
- BOX_COLOUR, 24'hFF0000, overlay border colour, {R,G,B}.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- mode  in  1  1 = draw overlay; 0 = pure pass-through.
- sink_data  in  24  RGB pixel {R[23:16],G[15:8],B[7:0]}.
- sink_valid  in  1  sink beat valid.
- sink_sop  in  1  start of packet.
- sink_eop  in  1  end of packet.
- sink_ready  out  1  stage can accept a beat.
- source_data  out  24  output pixel.
- source_valid  out  1  output beat valid.
- source_sop  out  1  start of packet.
- source_eop  out  1  end of packet.
- source_ready  in  1  downstream accepts.
- bbox_left, bbox_right  out  11 each  min/max x of matches in the last completed frame.
- bbox_top, bbox_bottom  out  10 each  min/max y of matches in the last completed frame.
- bbox_valid  out  1  last completed frame had at least one match.
- frame_done  out  1  one-cycle pulse when the bbox outputs update.

Behaviour:
Reset:
- Reset is synchronous and active-low.
- All outputs reset to 0, except sink_ready, which is 1 after reset.
- FSM returns to WAIT_SOP.
- Internal min/max trackers reset to min=max-value, max=0.

Handshake and latency:
- Single output register. sink_ready = !source_valid || source_ready.
- Accept = sink_valid && sink_ready. On accept, the registered source_* is loaded the next cycle.
- On source_valid && source_ready with no accept, source_valid drops to 0.
- Data, sop and eop are never altered except the overlay substitution of source_data.

FSM:
- WAIT_SOP: accepted beats without sop pass through and are not counted. An accepted sop beat with data[3:0]==0 goes to VIDEO; any other type goes to OTHER. The sop beat itself is a header and is never counted or overlaid.
- VIDEO: each accepted beat is a pixel at (x,y). x increments; at x==IMAGE_W-1 it wraps to 0 and y increments. Once y==IMAGE_H, further pixels are passed through but neither counted nor overlaid. An accepted eop goes to WAIT_SOP and commits results.
- OTHER: pass-through only. An accepted eop goes to WAIT_SOP.
- An sop while in VIDEO or OTHER (missing eop) is treated as a new header. The partial VIDEO frame is discarded without commit.

Match and overlay:
- Match = R>=R_MIN && G<=G_MAX && B<=B_MAX. On a match, update min/max x/y.
- Overlay applies when mode==1, bbox_valid==1, the pixel is in VIDEO, and it lies on the border of the committed box:
  - x in {left,right} and top<=y<=bottom, or
  - y in {top,bottom} and left<=x<=right.
- An overlaid pixel outputs BOX_COLOUR. mode is sampled per beat.

Commit (on the cycle after the eop beat is accepted in VIDEO):
- bbox_* get the trackers' values; bbox_valid = any match.
- If there were no matches, bbox coordinates are set to 0.
- frame_done pulses for 1 cycle; the trackers and x/y are cleared.
- This applies to short frames (eop before IMAGE_W*IMAGE_H pixels) too.

Stalls and reset mid-packet:
- Backpressure freezes x/y and the FSM. No beat may be lost or duplicated.
- Reset mid-packet aborts the frame without a frame_done pulse. The rest of that packet passes through in WAIT_SOP.

Decomposition:
- Package colour_bbox_pkg holds:
  - PKT_VIDEO=4'h0;
  - X_W=11, Y_W=10;
  - an rgb_t struct {r,g,b};
  - a bbox_t struct {left,right,top,bottom,valid}.
- Sub-module bbox_tracker: per-pixel min/max accumulation, clear, and commit-to-output register.
- FSM, counters and ST pipeline register stay in the top.

Test Plan:
- Reset and pass-through (IMAGE_W=8, IMAGE_H=4; mode=0; header 0x0 then 32 grey 0x404040 pixels with eop; source_ready=1):
  - Output is identical to input, 1-cycle latency.
  - frame_done pulses once with bbox_valid=0 and all coords 0.
- Single red pixel (0xFF0000 at x=3,y=2, rest grey):
  - bbox left=right=3, top=bottom=2, bbox_valid=1.
- Overlay (two reds at (1,1) and (5,2), then a second frame with mode=1):
  - Frame-2 pixels on the rectangle x=1..5, y=1..2 border output 0xFF0000; all others unchanged.
- Backpressure (toggle source_ready every other cycle over a full frame):
  - Exactly 33 beats out in order; bbox identical to the no-stall run; sink_ready low only while source_valid && !source_ready.
- Non-video packet (header 0xF, 4 red beats, eop):
  - Passes unchanged; no frame_done; bbox outputs unchanged.
- Reset mid-frame (reset_n low for 1 cycle after 10 pixels, then a complete frame with a red pixel at (7,3)):
  - No frame_done for the aborted frame; the next frame commits left=right=7, top=bottom=3.
